cd_tx_frame_ctrl: RTL and testbench

//  Frame sequencer for the byte-level TX serializer. On start it fetches frame_len payload bytes from the TX frame RAM,

---
 rtl/cd_tx_frame_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cd_tx_frame_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_tx_frame_ctrl.sv
// rtl/cd_tx_frame_ctrl.sv - frame sequencer feeding payload and CRC bytes to the TX serializer
module cd_tx_frame_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_len,
    input  logic [3:0]        max_retry,
    input  logic              break_req,
    input  logic              cancel,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        data,
    output logic              has_data,
    input  logic              ack_data,
    output logic              is_crc_byte,
    output logic              is_last_byte,
    input  logic [15:0]       crc_data,
    output logic              has_break,
    input  logic              ack_break,
    input  logic              cd,
    input  logic              err,
    output logic              abort,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [3:0]        retry_cnt
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, CRC_L, CRC_H, BRK} state_t;

    localparam logic [ADDR_W-1:0] IDX_ONE = 1;

    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, idx_n, len_q, len_n;
    logic [15:0]       crc_q, crc_n;
    logic [7:0]        data_n;
    logic              has_data_n, is_crc_n, is_last_n, has_break_n;
    logic              brk_pend, brk_pend_n;
    logic              abort_n, done_n, fail_n;
    logic [1:0]        fail_code_n;
    logic [3:0]        retry_n, retry_inc;

    assign rd_en   = (state == FETCH);
    assign rd_addr = idx;
    assign busy    = (state != IDLE);

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        len_n       = len_q;
        crc_n       = crc_q;
        data_n      = data;
        has_data_n  = has_data;
        is_crc_n    = is_crc_byte;
        is_last_n   = is_last_byte;
        has_break_n = has_break;
        brk_pend_n  = brk_pend | break_req;
        abort_n     = 1'b0;
        done_n      = 1'b0;
        fail_n      = 1'b0;
        fail_code_n = fail_code;
        retry_n     = retry_cnt;
        retry_inc   = (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;

        if (cancel && state != IDLE) begin
            abort_n     = 1'b1;
            has_data_n  = 1'b0;
            has_break_n = 1'b0;
            is_crc_n    = 1'b0;
            is_last_n   = 1'b0;
            fail_n      = 1'b1;
            fail_code_n = 2'd0;
            brk_pend_n  = 1'b0;
            state_n     = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (frame_len == '0) begin
                            fail_n      = 1'b1;
                            fail_code_n = 2'd3;
                        end else begin
                            idx_n       = '0;
                            len_n       = frame_len;
                            retry_n     = 4'd0;
                            fail_code_n = 2'd0;
                            state_n     = FETCH;
                        end
                    end else if (brk_pend) begin
                        has_break_n = 1'b1;
                        state_n     = BRK;
                    end
                end
                FETCH: state_n = LOAD;
                LOAD: begin
                    data_n     = rd_data;
                    has_data_n = 1'b1;
                    state_n    = SEND;
                end
                SEND, CRC_L, CRC_H: begin
                    // An ack in the same cycle as err/cd is deliberately dropped.
                    if (err) begin
                        has_data_n  = 1'b0;
                        is_crc_n    = 1'b0;
                        is_last_n   = 1'b0;
                        fail_n      = 1'b1;
                        fail_code_n = 2'd2;
                        state_n     = IDLE;
                    end else if (cd) begin
                        has_data_n = 1'b0;
                        is_crc_n   = 1'b0;
                        is_last_n  = 1'b0;
                        retry_n    = retry_inc;
                        if (retry_inc > max_retry) begin
                            fail_n      = 1'b1;
                            fail_code_n = 2'd1;
                            state_n     = IDLE;
                        end else begin
                            idx_n   = '0;
                            state_n = FETCH;
                        end
                    end else if (ack_data) begin
                        if (state == SEND) begin
                            if (idx + IDX_ONE < len_q) begin
                                idx_n   = idx + IDX_ONE;
                                state_n = FETCH;
                            end else begin
                                crc_n    = crc_data;
                                data_n   = crc_data[7:0];
                                is_crc_n = 1'b1;
                                state_n  = CRC_L;
                            end
                        end else if (state == CRC_L) begin
                            data_n    = crc_q[15:8];
                            is_last_n = 1'b1;
                            state_n   = CRC_H;
                        end else begin
                            has_data_n = 1'b0;
                            is_crc_n   = 1'b0;
                            is_last_n  = 1'b0;
                            done_n     = 1'b1;
                            state_n    = IDLE;
                        end
                    end
                end
                BRK: begin
                    if (ack_break) begin
                        brk_pend_n  = 1'b0;
                        has_break_n = 1'b0;
                        state_n     = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            len_q        <= '0;
            crc_q        <= '0;
            data         <= '0;
            has_data     <= 1'b0;
            is_crc_byte  <= 1'b0;
            is_last_byte <= 1'b0;
            has_break    <= 1'b0;
            brk_pend     <= 1'b0;
            abort        <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            fail_code    <= 2'd0;
            retry_cnt    <= 4'd0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            len_q        <= len_n;
            crc_q        <= crc_n;
            data         <= data_n;
            has_data     <= has_data_n;
            is_crc_byte  <= is_crc_n;
            is_last_byte <= is_last_n;
            has_break    <= has_break_n;
            brk_pend     <= brk_pend_n;
            abort        <= abort_n;
            done         <= done_n;
            fail         <= fail_n;
            fail_code    <= fail_code_n;
            retry_cnt    <= retry_n;
        end
    end

endmodule

// File: tb/tb_cd_tx_frame_ctrl.sv
// tb/tb_cd_tx_frame_ctrl.sv - randomized self-checking bench for cd_tx_frame_ctrl
module tb_cd_tx_frame_ctrl;

    localparam int ADDR_W = 8;
    localparam int EV_NONE = 0, EV_CD = 1, EV_ERR = 2, EV_CANCEL = 3, EV_RESET = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] frame_len = '0;
    logic [3:0]        max_retry = '0;
    logic              break_req = 1'b0;
    logic              cancel = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data = '0;
    logic [7:0]        data;
    logic              has_data;
    logic              ack_data = 1'b0;
    logic              is_crc_byte;
    logic              is_last_byte;
    logic [15:0]       crc_data = '0;
    logic              has_break;
    logic              ack_break = 1'b0;
    logic              cd = 1'b0;
    logic              err = 1'b0;
    logic              abort;
    logic              busy;
    logic              done;
    logic              fail;
    logic [1:0]        fail_code;
    logic [3:0]        retry_cnt;

    logic [7:0] ram [256];
    int         n_checks = 0;
    int         n_errors = 0;
    int         rd_count = 0;

    cd_tx_frame_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .frame_len(frame_len),
        .max_retry(max_retry), .break_req(break_req), .cancel(cancel),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .data(data),
        .has_data(has_data), .ack_data(ack_data), .is_crc_byte(is_crc_byte),
        .is_last_byte(is_last_byte), .crc_data(crc_data), .has_break(has_break),
        .ack_break(ack_break), .cd(cd), .err(err), .abort(abort), .busy(busy),
        .done(done), .fail(fail), .fail_code(fail_code), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data  <= ram[rd_addr];
            rd_count <= rd_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {rd_en, rd_addr, data, has_data, is_crc_byte, is_last_byte,
                               has_break, abort, busy, done, fail, fail_code, retry_cnt}, 0);
    endtask

    // One frame through a serializer model. The expected byte stream is the payload
    // from the RAM followed by the two CRC bytes; an event (cd/err/cancel/reset) is
    // injected at byte position pos during the first 'passes' transmission passes.
    task automatic run_frame(input int len, input int mr, input int kind, input int pos,
                             input int passes, input bit brk);
        int          retries, pass, budget;
        bit          finished, restart, brk_sent, killed;
        logic [15:0] crc;
        logic [7:0]  exp_b;

        retries  = 0;
        pass     = 0;
        finished = 0;
        brk_sent = 0;
        killed   = 0;
        crc       = 16'($urandom);
        crc_data  = crc;
        frame_len = len[ADDR_W-1:0];
        max_retry = mr[3:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);

        while (!finished) begin
            budget = 0;
            while (!has_data && budget < 10) begin
                @(negedge clk);
                budget++;
            end
            check("first_byte_ready", has_data, 1);
            if (!has_data) begin
                finished = 1;
                killed   = 1;
            end
            restart = 0;
            for (int p = 0; p < len + 2 && !finished && !restart; p++) begin
                if (p > 0) repeat (3) @(negedge clk);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                exp_b = (p < len) ? ram[p] : ((p == len) ? crc[7:0] : crc[15:8]);
                check("data", data, exp_b);
                check("has_data", has_data, 1);
                check("is_crc_byte", is_crc_byte, p >= len);
                check("is_last_byte", is_last_byte, p == len + 1);
                if (pass == 0 && p == 0) start = 1'b1;
                if (brk && pass == 0 && p == 1) begin
                    break_req = 1'b1;
                    brk_sent  = 1;
                end
                if (kind != EV_NONE && p == pos && pass < passes) begin
                    if (kind == EV_RESET) begin
                        reset_n = 1'b0;
                        #1;
                        check_all_zero("reset_mid_frame");
                        @(negedge clk);
                        start     = 1'b0;
                        break_req = 1'b0;
                        reset_n   = 1'b1;
                        killed    = 1;
                        finished  = 1;
                    end else begin
                        cd     = (kind == EV_CD);
                        err    = (kind == EV_ERR);
                        cancel = (kind == EV_CANCEL);
                        @(negedge clk);
                        {start, break_req, cd, err, cancel} = '0;
                        check("has_data_drop", has_data, 0);
                        if (kind == EV_CD) begin
                            retries = (retries == 15) ? 15 : retries + 1;
                            check("retry_cnt", retry_cnt, retries);
                            if (retries > mr) begin
                                check("fail_retry", fail, 1);
                                check("fail_code_retry", fail_code, 1);
                                finished = 1;
                            end else begin
                                check("no_fail_on_retry", fail, 0);
                                check("busy_on_retry", busy, 1);
                                pass++;
                                restart = 1;
                            end
                        end else if (kind == EV_ERR) begin
                            check("fail_err", fail, 1);
                            check("fail_code_err", fail_code, 2);
                            finished = 1;
                        end else begin
                            check("abort", abort, 1);
                            check("fail_cancel", fail, 1);
                            check("fail_code_cancel", fail_code, 0);
                            check("busy_cancel", busy, 0);
                            @(negedge clk);
                            check("abort_pulse_len", abort, 0);
                            killed   = 1;
                            finished = 1;
                        end
                    end
                end else begin
                    ack_data = 1'b1;
                    @(negedge clk);
                    {start, break_req, ack_data} = '0;
                    if (p == len + 1) begin
                        check("done", done, 1);
                        check("has_data_end", has_data, 0);
                        check("flags_end", {is_crc_byte, is_last_byte}, 0);
                        check("retry_cnt_done", retry_cnt, retries);
                        @(negedge clk);
                        check("done_pulse_len", done, 0);
                        finished = 1;
                    end
                end
            end
        end

        if (brk_sent && !killed) begin
            budget = 0;
            while (!has_break && budget < 6) begin
                @(negedge clk);
                budget++;
            end
            check("has_break", has_break, 1);
            check("busy_brk", busy, 1);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            ack_break = 1'b1;
            @(negedge clk);
            ack_break = 1'b0;
            check("has_break_clear", has_break, 0);
            check("busy_after_brk", busy, 0);
            check("no_done_brk", done, 0);
        end else begin
            repeat (3) @(negedge clk);
            check("idle_no_break", {has_break, busy}, 0);
        end
    endtask

    initial begin
        int rd_before, len, mr, kind, passes;
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        ram[0] = 8'h11;
        ram[1] = 8'h22;
        ram[2] = 8'h33;

        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");

        run_frame(3, 0, EV_NONE, 0, 0, 0);
        run_frame(3, 1, EV_CD, 1, 1, 0);
        run_frame(3, 1, EV_CD, 1, 2, 0);
        run_frame(3, 0, EV_ERR, 3, 1, 0);
        run_frame(3, 0, EV_NONE, 0, 0, 1);
        run_frame(3, 0, EV_CANCEL, 1, 1, 1);

        rd_before = rd_count;
        frame_len = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fail_len0", fail, 1);
        check("fail_code_len0", fail_code, 3);
        check("busy_len0", busy, 0);
        @(negedge clk);
        check("fail_len0_pulse", fail, 0);
        check("no_rd_len0", rd_count, rd_before);

        run_frame(3, 0, EV_RESET, 4, 1, 0);
        check_all_zero("post_reset");
        run_frame(3, 0, EV_NONE, 0, 0, 0);
        run_frame(255, 0, EV_NONE, 0, 0, 0);
        run_frame(1, 15, EV_CD, 0, 3, 0);

        for (int n = 0; n < 24; n++) begin
            len    = $urandom_range(1, 8);
            mr     = $urandom_range(0, 3);
            kind   = $urandom_range(0, 3);
            passes = $urandom_range(1, 4);
            run_frame(len, mr, kind, $urandom_range(0, len + 1), passes, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
